// File: rtl/mem_access_unit.sv
// Load/store bus adapter: aligns sub-word accesses onto a 32-bit word bus,
// extends load data, and aborts stalled transfers with a 16-cycle watchdog.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadData,
  output logic        Busy,
  output logic        Done,
  output logic        AddrErr,
  output logic        BusErr
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [1:0]  size_reg;
  logic        unsigned_reg;
  logic        read_reg;
  logic        write_reg;
  logic [3:0]  wdog_reg;
  logic [31:0] read_data_reg;
  logic        addr_err_reg;
  logic        bus_err_reg;

  logic        req_any;
  logic        illegal;
  logic        in_access;
  logic        wdog_expired;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_value;
  logic [3:0]  be_value;
  logic [31:0] wdata_value;

  assign req_any = MemRead | MemWrite;
  assign illegal = (Size == 2'b11)
                 | (MemRead & MemWrite)
                 | ((Size == 2'b01) & ALUResult[0])
                 | ((Size == 2'b10) & (ALUResult[1:0] != 2'b00));

  assign in_access    = (state_reg == ACCESS);
  assign wdog_expired = (wdog_reg == 4'd15);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (Start) begin
          // A request with no direction completes immediately without error.
          state_next = (req_any && !illegal) ? ACCESS : DONE;
        end
      end
      ACCESS: begin
        if (mem_ready || wdog_expired) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    case (addr_reg[1:0])
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = addr_reg[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_reg)
      2'b00:   load_value = {{24{~unsigned_reg & byte_sel[7]}}, byte_sel};
      2'b01:   load_value = {{16{~unsigned_reg & half_sel[15]}}, half_sel};
      default: load_value = mem_rdata;
    endcase
  end

  always_comb begin
    case (size_reg)
      2'b00: begin
        be_value    = 4'b0001 << addr_reg[1:0];
        wdata_value = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        be_value    = addr_reg[1] ? 4'b1100 : 4'b0011;
        wdata_value = {2{wdata_reg[15:0]}};
      end
      default: begin
        be_value    = 4'b1111;
        wdata_value = wdata_reg;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_reg      <= '0;
      wdata_reg     <= '0;
      size_reg      <= '0;
      unsigned_reg  <= 1'b0;
      read_reg      <= 1'b0;
      write_reg     <= 1'b0;
      wdog_reg      <= '0;
      read_data_reg <= '0;
      addr_err_reg  <= 1'b0;
      bus_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (Start) begin
            addr_reg      <= ALUResult;
            wdata_reg     <= WriteData;
            size_reg      <= Size;
            unsigned_reg  <= Unsigned;
            read_reg      <= MemRead;
            write_reg     <= MemWrite;
            wdog_reg      <= '0;
            read_data_reg <= '0;
            addr_err_reg  <= req_any & illegal;
            bus_err_reg   <= 1'b0;
          end
        end
        ACCESS: begin
          // A ready arriving on the final watchdog cycle still wins.
          if (mem_ready) begin
            if (read_reg) begin
              read_data_reg <= load_value;
            end
          end else if (wdog_expired) begin
            bus_err_reg <= 1'b1;
          end else begin
            wdog_reg <= wdog_reg + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_req   = in_access;
  assign mem_we    = in_access & write_reg;
  assign mem_addr  = in_access ? {addr_reg[31:2], 2'b00} : 32'd0;
  assign mem_be    = in_access ? be_value : 4'b0000;
  assign mem_wdata = in_access ? wdata_value : 32'd0;
  assign ReadData  = read_data_reg;
  assign Busy      = (state_reg != IDLE);
  assign Done      = (state_reg == DONE);
  assign AddrErr   = addr_err_reg;
  assign BusErr    = bus_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Size;
  logic        Unsigned;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] ReadData;
  logic        Busy;
  logic        Done;
  logic        AddrErr;
  logic        BusErr;

  int passed = 0;
  int total  = 0;

  mem_access_unit dut (
    .clk(clk), .reset(reset), .Start(Start), .ALUResult(ALUResult),
    .WriteData(WriteData), .MemRead(MemRead), .MemWrite(MemWrite),
    .Size(Size), .Unsigned(Unsigned), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .ReadData(ReadData),
    .Busy(Busy), .Done(Done), .AddrErr(AddrErr), .BusErr(BusErr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_req(input logic [31:0] addr, input logic [31:0] wd,
                           input logic rd, input logic wr,
                           input logic [1:0] sz, input logic un);
    ALUResult = addr; WriteData = wd; MemRead = rd; MemWrite = wr;
    Size = sz; Unsigned = un; Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; Start = 0; ALUResult = 0; WriteData = 0; MemRead = 0;
    MemWrite = 0; Size = 0; Unsigned = 0; mem_ready = 0; mem_rdata = 0;
    #12;
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadData, Busy, Done, AddrErr, BusErr} !== '0)
      $display("FAIL reset_outputs: req=%b we=%b be=%h addr=%h wdata=%h rd=%h busy=%b done=%b ae=%b be=%b, required all zero",
               mem_req, mem_we, mem_be, mem_addr, mem_wdata, ReadData, Busy, Done, AddrErr, BusErr);
    else passed++;
    @(posedge clk); #1 reset = 1'b0;
    tick();
    total++;
    if ({Busy, Done, mem_req} !== 3'b000) $display("FAIL after_reset_idle: busy/done/req=%b required 000", {Busy, Done, mem_req});
    else passed++;
    $display("reset sequence complete");
  endtask

  task automatic test_word_load;
    mem_rdata = 32'hDEADBEEF; mem_ready = 1'b1;
    start_req(32'h104, 32'h0, 1, 0, 2'b10, 0);
    total++;
    if ({mem_req, mem_we, mem_be, mem_addr, Busy, Done} !== {1'b1, 1'b0, 4'hF, 32'h104, 1'b1, 1'b0})
      $display("FAIL word_load_bus: req=%b we=%b be=%h addr=%h busy=%b done=%b, required 1 0 f 00000104 1 0",
               mem_req, mem_we, mem_be, mem_addr, Busy, Done);
    else passed++;
    tick();
    total++;
    if ({Done, ReadData, mem_req, mem_be} !== {1'b1, 32'hDEADBEEF, 1'b0, 4'h0})
      $display("FAIL word_load_done: done=%b rd=%h req=%b be=%h, required 1 deadbeef 0 0", Done, ReadData, mem_req, mem_be);
    else passed++;
    mem_ready = 1'b0;
    tick();
    total++;
    if ({Done, Busy, ReadData} !== {1'b0, 1'b0, 32'hDEADBEEF})
      $display("FAIL word_load_hold: done=%b busy=%b rd=%h, required 0 0 deadbeef", Done, Busy, ReadData);
    else passed++;
    $display("word load addr=00000104 rdata=deadbeef ReadData=%h", ReadData);
  endtask

  task automatic test_sub_word_load;
    mem_rdata = 32'h80112233; mem_ready = 1'b1;
    start_req(32'h103, 32'h0, 1, 0, 2'b00, 0);
    total++;
    if (mem_be !== 4'b1000) $display("FAIL byte_load_be: be=%b required 1000", mem_be);
    else passed++;
    tick();
    total++;
    if (ReadData !== 32'hFFFFFF80) $display("FAIL byte_load_signed: rd=%h required ffffff80", ReadData);
    else passed++;
    tick();
    start_req(32'h103, 32'h0, 1, 0, 2'b00, 1);
    tick();
    total++;
    if (ReadData !== 32'h00000080) $display("FAIL byte_load_unsigned: rd=%h required 00000080", ReadData);
    else passed++;
    tick();
    start_req(32'h102, 32'h0, 1, 0, 2'b01, 0);
    total++;
    if (mem_be !== 4'b1100) $display("FAIL half_load_be: be=%b required 1100", mem_be);
    else passed++;
    tick();
    total++;
    if (ReadData !== 32'hFFFF8011) $display("FAIL half_load_signed: rd=%h required ffff8011", ReadData);
    else passed++;
    mem_ready = 1'b0;
    tick();
    $display("sub-word loads from rdata=80112233 last ReadData=%h", ReadData);
  endtask

  task automatic test_store;
    mem_ready = 1'b1;
    start_req(32'h22, 32'h1234ABCD, 0, 1, 2'b01, 0);
    total++;
    if ({mem_we, mem_be, mem_wdata, mem_addr} !== {1'b1, 4'b1100, 32'hABCDABCD, 32'h20})
      $display("FAIL half_store_bus: we=%b be=%b wdata=%h addr=%h, required 1 1100 abcdabcd 00000020",
               mem_we, mem_be, mem_wdata, mem_addr);
    else passed++;
    tick();
    total++;
    if ({Done, ReadData} !== {1'b1, 32'h0}) $display("FAIL half_store_done: done=%b rd=%h, required 1 00000000", Done, ReadData);
    else passed++;
    tick();
    start_req(32'h41, 32'hCAFE005A, 0, 1, 2'b00, 0);
    total++;
    if ({mem_be, mem_wdata, mem_addr} !== {4'b0010, 32'h5A5A5A5A, 32'h40})
      $display("FAIL byte_store_bus: be=%b wdata=%h addr=%h, required 0010 5a5a5a5a 00000040", mem_be, mem_wdata, mem_addr);
    else passed++;
    tick();
    mem_ready = 1'b0;
    tick();
    $display("stores half@00000022 byte@00000041 done");
  endtask

  task automatic test_errors;
    start_req(32'h6, 32'h0, 1, 0, 2'b10, 0);
    total++;
    if ({Done, AddrErr, mem_req, BusErr} !== 4'b1100)
      $display("FAIL misaligned_word: done=%b ae=%b req=%b buserr=%b, required 1 1 0 0", Done, AddrErr, mem_req, BusErr);
    else passed++;
    tick();
    total++;
    if ({Done, Busy, AddrErr, ReadData} !== {1'b0, 1'b0, 1'b1, 32'h0})
      $display("FAIL misaligned_hold: done=%b busy=%b ae=%b rd=%h, required 0 0 1 0", Done, Busy, AddrErr, ReadData);
    else passed++;
    start_req(32'h8, 32'h0, 1, 0, 2'b11, 0);
    total++;
    if ({Done, AddrErr, mem_req} !== 3'b110) $display("FAIL reserved_size: done/ae/req=%b required 110", {Done, AddrErr, mem_req});
    else passed++;
    tick();
    start_req(32'h8, 32'h0, 1, 1, 2'b10, 0);
    total++;
    if ({Done, AddrErr, mem_req} !== 3'b110) $display("FAIL read_and_write: done/ae/req=%b required 110", {Done, AddrErr, mem_req});
    else passed++;
    tick();
    start_req(32'h21, 32'h0, 1, 0, 2'b01, 0);
    total++;
    if ({Done, AddrErr, mem_req} !== 3'b110) $display("FAIL misaligned_half: done/ae/req=%b required 110", {Done, AddrErr, mem_req});
    else passed++;
    tick();
    start_req(32'h8, 32'h0, 0, 0, 2'b10, 0);
    total++;
    if ({Done, AddrErr, mem_req} !== 3'b100) $display("FAIL noop_request: done/ae/req=%b required 100", {Done, AddrErr, mem_req});
    else passed++;
    tick();
    $display("error cases complete");
  endtask

  task automatic test_timeout;
    int cnt = 0;
    mem_ready = 1'b0; mem_rdata = 32'h11112222;
    start_req(32'h200, 32'h0, 1, 0, 2'b10, 0);
    for (int i = 0; i < 40; i++) begin
      if (!mem_req) break;
      cnt++;
      if (cnt == 3) begin
        ALUResult = 32'h300; Start = 1'b1;
      end else begin
        Start = 1'b0;
      end
      tick();
    end
    Start = 1'b0;
    total++;
    if (cnt !== 16) $display("FAIL timeout_req_cycles: got %0d required 16", cnt);
    else passed++;
    total++;
    if ({Done, BusErr, AddrErr, ReadData} !== {1'b1, 1'b1, 1'b0, 32'h0})
      $display("FAIL timeout_done: done=%b buserr=%b ae=%b rd=%h, required 1 1 0 0", Done, BusErr, AddrErr, ReadData);
    else passed++;
    tick();
    tick();
    total++;
    if ({Busy, mem_req, BusErr} !== 3'b001) $display("FAIL timeout_no_queue: busy/req/buserr=%b required 001", {Busy, mem_req, BusErr});
    else passed++;
    $display("timeout after %0d request cycles", cnt);
  endtask

  task automatic test_ready_at_limit;
    mem_ready = 1'b0; mem_rdata = 32'h0BADF00D;
    start_req(32'h10, 32'h0, 1, 0, 2'b10, 0);
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (mem_req !== 1'b1) $display("FAIL limit_still_req: req=%b required 1", mem_req);
    else passed++;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    total++;
    if ({Done, BusErr, ReadData} !== {1'b1, 1'b0, 32'h0BADF00D})
      $display("FAIL limit_ready_success: done=%b buserr=%b rd=%h, required 1 0 0badf00d", Done, BusErr, ReadData);
    else passed++;
    tick();
    $display("ready on final watchdog cycle ReadData=%h", ReadData);
  endtask

  task automatic test_reset_mid_access;
    int dones = 0;
    mem_ready = 1'b0;
    start_req(32'h50, 32'h0, 1, 0, 2'b10, 0);
    tick(); tick();
    #2 reset = 1'b1;
    #1;
    total++;
    if ({mem_req, Busy, mem_be} !== 6'b0) $display("FAIL reset_async_drop: req=%b busy=%b be=%b, required 0 0 0000", mem_req, Busy, mem_be);
    else passed++;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (Done) dones++;
      tick();
    end
    total++;
    if (dones !== 0) $display("FAIL reset_no_done: got %0d pulses required 0", dones);
    else passed++;
    mem_ready = 1'b1; mem_rdata = 32'h13572468;
    start_req(32'h54, 32'h0, 1, 0, 2'b10, 0);
    total++;
    if ({mem_req, mem_addr} !== {1'b1, 32'h54}) $display("FAIL post_reset_req: req=%b addr=%h required 1 00000054", mem_req, mem_addr);
    else passed++;
    tick();
    mem_ready = 1'b0;
    total++;
    if ({Done, ReadData} !== {1'b1, 32'h13572468}) $display("FAIL post_reset_load: done=%b rd=%h required 1 13572468", Done, ReadData);
    else passed++;
    tick();
    $display("reset mid-access then load ReadData=%h", ReadData);
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_sub_word_load();
    test_store();
    test_errors();
    test_timeout();
    test_ready_at_limit();
    test_reset_mid_access();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset; ports clk and reset; all state updates on rising clk.
REQ-002 SHALL provide ports (name direction width meaning):
 clk  in  1  clock
 reset  in  1  async active-high reset
 Start  in  1  accept new access when idle
 ALUResult  in  32  byte address from ALU
 WriteData  in  32  store data (low bits used for sub-word)
 MemRead  in  1  load request
 MemWrite  in  1  store request
 Size  in  2  00 byte, 01 half, 10 word, 11 reserved
 Unsigned  in  1  zero-extend loads when 1, else sign-extend
 mem_req  out  1  bus request
 mem_we  out  1  bus write strobe
 mem_addr  out  32  word-aligned bus address
 mem_be  out  4  byte enables, lane i = bits [8i+7:8i]
 mem_wdata  out  32  bus store data
 mem_ready  in  1  bus completion
 mem_rdata  in  32  bus read data
 ReadData  out  32  extended load result
 Busy  out  1  access in progress
 Done  out  1  one-cycle completion pulse
 AddrErr  out  1  misaligned/illegal request, valid with Done
 BusErr  out  1  bus timeout, valid with Done

Function
REQ-003 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-004 IDLE: Start=1 -> register address, data, Size, Unsigned, and direction; go to ACCESS if legal, else DONE with AddrErr=1.
REQ-005 Illegal: Size=11; MemRead=MemWrite=1; half with addr[0]=1; word with addr[1:0]!=00.
REQ-006 Start with MemRead=MemWrite=0 SHALL go to DONE without bus activity; AddrErr=0.
REQ-007 ACCESS: mem_req=1; mem_we=registered MemWrite; mem_addr={addr[31:2],2'b00}; held stable until mem_ready=1.
REQ-008 mem_be: byte -> 1<<addr[1:0]; half -> 0011 (addr[1]=0) or 1100; word -> 1111; mem_be SHALL be 0000 outside ACCESS.
REQ-009 mem_wdata: byte -> {4{WriteData[7:0]}}; half -> {2{WriteData[15:0]}}; word -> WriteData.
REQ-010 mem_ready=1 in ACCESS -> go to DONE next edge; on load, capture lane-extracted mem_rdata into ReadData.
REQ-011 Load extraction: byte from lane addr[1:0], half from lane addr[1]*2; bits above width = sign bit if Unsigned=0, else 0.
REQ-012 Watchdog: 4-bit counter cleared on ACCESS entry, increments each ACCESS cycle without mem_ready; when count reaches 15 without mem_ready, SHALL go to DONE with BusErr=1 and ReadData=0.
REQ-013 mem_ready sampled in the same cycle the counter reaches 15 SHALL count as success (BusErr=0).
REQ-014 DONE: Done=1 for exactly one cycle, then IDLE; Start in DONE ignored.
REQ-015 Busy=1 in ACCESS and DONE; Start while Busy SHALL be ignored and never queued.
REQ-016 ReadData, AddrErr, BusErr SHALL hold last values until the next accepted Start, which clears them.
REQ-017 Store or error completion SHALL leave ReadData=0.
REQ-018 mem_ready outside ACCESS SHALL be ignored.
REQ-019 Minimum latency: Start at edge N, mem_req high cycle N+1, mem_ready same cycle -> Done high cycle N+2.

Reset
REQ-020 reset=1 SHALL force IDLE immediately, independent of clk.
REQ-021 During and after reset: mem_req=0, mem_we=0, mem_be=0000, mem_addr=0, mem_wdata=0, ReadData=0, Busy=0, Done=0, AddrErr=0, BusErr=0, watchdog=0.
REQ-022 reset mid-ACCESS SHALL drop mem_req asynchronously and discard the access; no Done pulse.

Verification
REQ-023 Word load: addr 0x00000104, MemRead, Size=10, mem_rdata 0xDEADBEEF, mem_ready 1st ACCESS cycle -> mem_addr 0x104, mem_be 1111, Done at N+2, ReadData 0xDEADBEEF.
REQ-024 Signed byte load: addr 0x00000103, Size=00, Unsigned=0, mem_rdata 0x80112233 -> mem_be 1000, ReadData 0xFFFFFF80; Unsigned=1 -> 0x00000080.
REQ-025 Half store: addr 0x00000022, WriteData 0x1234ABCD, Size=01 -> mem_we=1, mem_be 1100, mem_wdata 0xABCDABCD, mem_addr 0x20.
REQ-026 Misaligned word: addr 0x00000006, Size=10 -> mem_req never asserted, Done at N+1 with AddrErr=1.
REQ-027 Timeout: mem_ready held 0 -> mem_req high 16 cycles, then Done with BusErr=1, ReadData 0; second Start during ACCESS ignored.
REQ-028 Reset mid-ACCESS at cycle 3 -> mem_req 0 immediately, no Done, next Start proceeds normally.
